// File: rtl/scarv_axi_sram_resp_if.sv
// AXI4-lite bus bundle between a master and the SRAM responder.
// Carries the AW, W, B, AR and R channels; no response codes are carried.
// master: drives valids, addresses, write data and the B/R readies.
// slave : drives the AW/W/AR readies, B/R valids and read data.
interface scarv_axi_sram_resp_if;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;

  logic        axi_wvalid;
  logic        axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;

  logic        axi_bvalid;
  logic        axi_bready;

  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;

  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;

  modport master (
    output axi_awvalid, axi_awaddr, axi_awprot,
    input  axi_awready,
    output axi_wvalid, axi_wdata, axi_wstrb,
    input  axi_wready,
    input  axi_bvalid,
    output axi_bready,
    output axi_arvalid, axi_araddr, axi_arprot,
    input  axi_arready,
    input  axi_rvalid, axi_rdata,
    output axi_rready
  );

  modport slave (
    input  axi_awvalid, axi_awaddr, axi_awprot,
    output axi_awready,
    input  axi_wvalid, axi_wdata, axi_wstrb,
    output axi_wready,
    output axi_bvalid,
    input  axi_bready,
    input  axi_arvalid, axi_araddr, axi_arprot,
    output axi_arready,
    output axi_rvalid, axi_rdata,
    input  axi_rready
  );
endinterface

// File: rtl/scarv_axi_sram_resp.sv
// AXI4-lite responder backed by a 2^DEPTH_LOG2 x 32-bit word array.
// Independent read and write paths, one outstanding transaction each,
// LATENCY extra wait cycles before every response.
// Ports:
//   g_clk    - clock, rising edge
//   g_resetn - asynchronous active-low reset
//   bus      - AXI4-lite slave modport (AW, W, B, AR, R channels)
//   err      - sticky flag, set by any out-of-range access until reset
module scarv_axi_sram_resp #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                        g_clk,
  input  logic                        g_resetn,
  scarv_axi_sram_resp_if.slave        bus,
  output logic                        err
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);
  localparam bit          NO_WAIT  = (LATENCY == 0);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  // In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; the shift form
  // avoids overflowing the upper bound for large arrays.
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return DEPTH_LOG2'(off >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------- write path
  w_state_t         w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             aw_got;
  logic             w_got;
  logic [31:0]      aw_addr_q;
  logic [31:0]      w_data_q;
  logic [3:0]       w_strb_q;

  logic             aw_hs;
  logic             w_hs;
  logic             aw_have;
  logic             w_have;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             wr_commit;
  logic             wr_ok;

  assign aw_hs   = bus.axi_awvalid & bus.axi_awready;
  assign w_hs    = bus.axi_wvalid  & bus.axi_wready;
  assign aw_have = aw_got | aw_hs;
  assign w_have  = w_got  | w_hs;

  // A channel captured in an earlier cycle comes from its register; one
  // arriving this cycle (zero-latency commit) comes straight off the bus.
  assign wr_addr = aw_got ? aw_addr_q : bus.axi_awaddr;
  assign wr_data = w_got  ? w_data_q  : bus.axi_wdata;
  assign wr_strb = w_got  ? w_strb_q  : bus.axi_wstrb;

  // Commit happens on the edge that moves the FSM into W_RESP.
  assign wr_commit = ((w_state == W_IDLE) && aw_have && w_have && NO_WAIT) ||
                     ((w_state == W_WAIT) && (w_cnt == '0));
  assign wr_ok     = in_range(wr_addr);

  // Write FSM with registered readies and bvalid.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      w_state         <= W_IDLE;
      w_cnt           <= '0;
      aw_got          <= 1'b0;
      w_got           <= 1'b0;
      aw_addr_q       <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      bus.axi_awready <= 1'b0;
      bus.axi_wready  <= 1'b0;
      bus.axi_bvalid  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got    <= 1'b1;
            aw_addr_q <= bus.axi_awaddr;
          end
          if (w_hs) begin
            w_got    <= 1'b1;
            w_data_q <= bus.axi_wdata;
            w_strb_q <= bus.axi_wstrb;
          end
          if (aw_have && w_have) begin
            bus.axi_awready <= 1'b0;
            bus.axi_wready  <= 1'b0;
            if (NO_WAIT) begin
              w_state        <= W_RESP;
              bus.axi_bvalid <= 1'b1;
            end else begin
              w_state <= W_WAIT;
              w_cnt   <= CNT_LOAD;
            end
          end else begin
            bus.axi_awready <= ~aw_have;
            bus.axi_wready  <= ~w_have;
          end
        end
        W_WAIT: begin
          if (w_cnt == '0) begin
            w_state        <= W_RESP;
            bus.axi_bvalid <= 1'b1;
          end else begin
            w_cnt <= w_cnt - CNT_W'(1);
          end
        end
        W_RESP: begin
          if (bus.axi_bready) begin
            w_state         <= W_IDLE;
            bus.axi_bvalid  <= 1'b0;
            aw_got          <= 1'b0;
            w_got           <= 1'b0;
            bus.axi_awready <= 1'b1;
            bus.axi_wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge g_clk) begin
    if (wr_commit && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_t         r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      ar_addr_q;

  logic             ar_hs;
  logic [31:0]      rd_addr;
  logic             rd_sample;
  logic             rd_ok;

  assign ar_hs     = bus.axi_arvalid & bus.axi_arready;
  assign rd_addr   = (r_state == R_IDLE) ? bus.axi_araddr : ar_addr_q;
  assign rd_sample = ((r_state == R_IDLE) && ar_hs && NO_WAIT) ||
                     ((r_state == R_WAIT) && (r_cnt == '0));
  assign rd_ok     = in_range(rd_addr);

  // Read FSM; rdata is sampled on entry to R_RESP, so a same-edge commit
  // to the same word is not yet visible and the old value is returned.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state         <= R_IDLE;
      r_cnt           <= '0;
      ar_addr_q       <= '0;
      bus.axi_arready <= 1'b0;
      bus.axi_rvalid  <= 1'b0;
      bus.axi_rdata   <= '0;
    end else begin
      if (rd_sample) begin
        bus.axi_rdata <= rd_ok ? mem[word_idx(rd_addr)] : 32'h0;
      end
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            bus.axi_arready <= 1'b0;
            ar_addr_q       <= bus.axi_araddr;
            if (NO_WAIT) begin
              r_state        <= R_RESP;
              bus.axi_rvalid <= 1'b1;
            end else begin
              r_state <= R_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end else begin
            bus.axi_arready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            r_state        <= R_RESP;
            bus.axi_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        R_RESP: begin
          if (bus.axi_rready) begin
            r_state         <= R_IDLE;
            bus.axi_rvalid  <= 1'b0;
            bus.axi_arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Sticky error: any out-of-range commit or sample.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      err <= 1'b0;
    end else if ((wr_commit && !wr_ok) || (rd_sample && !rd_ok)) begin
      err <= 1'b1;
    end
  end

  // Protection bits carry no meaning for this memory.
  logic unused_prot;
  assign unused_prot = ^{bus.axi_awprot, bus.axi_arprot};

endmodule
